// File: rtl/ifft_8point_16bit_stream.sv
// 8-point complex IFFT, 16-bit streaming, scaled by 1/8 (one halving per stage).
// Bins are accepted serially and stored bit-reversed. Three in-place radix-2
// DIT stages run one per cycle, and the samples are then streamed out in
// natural order.
//
// state  | meaning
// LOAD   | accepting bins 0..7 into the buffer at bit-reversed addresses
// ST1    | butterflies on pairs (0,1)(2,3)(4,5)(6,7), twiddle 1
// ST2    | butterflies on pairs (0,2)(4,6) with twiddle 1, and (1,3)(5,7) with twiddle +j
// ST3    | butterflies on pairs (0,4)(1,5)(2,6)(3,7) with twiddles 1, (1+j)/sqrt2, +j, (-1+j)/sqrt2
// UNLOAD | presenting buffer[counter] on the output until index 7 is accepted
module ifft_8point_16bit_stream #(
    parameter int W   = 16,
    parameter int C45 = 23170
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                out_last
);

    typedef enum logic [2:0] {LOAD, ST1, ST2, ST3, UNLOAD} state_t;

    typedef struct packed {
        logic signed [W-1:0] a_re;
        logic signed [W-1:0] a_im;
        logic signed [W-1:0] b_re;
        logic signed [W-1:0] b_im;
    } bfly_t;

    // Twiddle arithmetic is done at W+2 bits so that no intermediate can wrap,
    // even for full-scale inputs.
    localparam logic signed [W+1:0]   C45_X = (W+2)'(C45);
    localparam logic signed [2*W+3:0] RND   = (2*W+4)'(1) <<< (W-2);

    state_t              state;
    logic [2:0]          cnt;
    logic signed [W-1:0] mem_re [8];
    logic signed [W-1:0] mem_im [8];
    logic signed [W-1:0] st_re  [8];
    logic signed [W-1:0] st_im  [8];
    logic [2:0]          pa;
    logic [2:0]          pb;
    logic [1:0]          ptw;
    bfly_t               bf;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Scale by cos(pi/4) in Q1.15, rounding half up.
    function automatic logic signed [W+1:0] mul45(input logic signed [W+1:0] d);
        logic signed [2*W+3:0] p;
        p = {{(W+2){d[W+1]}}, d} * {{(W+2){C45_X[W+1]}}, C45_X};
        p = p + RND;
        return p[2*W:W-1];
    endfunction

    // One radix-2 butterfly with a halving output: A' = (A+tB)/2 and B' = (A-tB)/2, using floor.
    function automatic bfly_t bfly(input logic signed [W-1:0] a_re,
                                   input logic signed [W-1:0] a_im,
                                   input logic signed [W-1:0] b_re,
                                   input logic signed [W-1:0] b_im,
                                   input logic [1:0]          tw);
        logic signed [W+1:0] ar, ai, br, bi, tr, ti, s_re, s_im, d_re, d_im;
        bfly_t r;
        ar = {{2{a_re[W-1]}}, a_re};
        ai = {{2{a_im[W-1]}}, a_im};
        br = {{2{b_re[W-1]}}, b_re};
        bi = {{2{b_im[W-1]}}, b_im};
        case (tw)
            2'd0: begin
                tr = br;
                ti = bi;
            end
            2'd1: begin
                tr = mul45(br - bi);
                ti = mul45(br + bi);
            end
            2'd2: begin
                tr = -bi;
                ti = br;
            end
            default: begin
                tr = mul45(-(br + bi));
                ti = mul45(br - bi);
            end
        endcase
        s_re = ar + tr;
        s_im = ai + ti;
        d_re = ar - tr;
        d_im = ai - ti;
        r.a_re = s_re[W:1];
        r.a_im = s_im[W:1];
        r.b_re = d_re[W:1];
        r.b_im = d_im[W:1];
        return r;
    endfunction

    assign in_ready = en && (state == LOAD);

    // Compute the result of the current stage for all four butterflies from the buffer.
    always_comb begin
        pa  = '0;
        pb  = '0;
        ptw = '0;
        bf  = '0;
        for (int i = 0; i < 8; i++) begin
            st_re[i] = mem_re[i];
            st_im[i] = mem_im[i];
        end
        for (int p = 0; p < 4; p++) begin
            case (state)
                ST2: begin
                    pa  = 3'((p / 2) * 4 + (p % 2));
                    pb  = pa + 3'd2;
                    ptw = (p % 2 == 1) ? 2'd2 : 2'd0;
                end
                ST3: begin
                    pa  = 3'(p);
                    pb  = pa + 3'd4;
                    ptw = 2'(p);
                end
                default: begin
                    pa  = 3'(p * 2);
                    pb  = pa + 3'd1;
                    ptw = 2'd0;
                end
            endcase
            bf = bfly(mem_re[pa], mem_im[pa], mem_re[pb], mem_im[pb], ptw);
            st_re[pa] = bf.a_re;
            st_im[pa] = bf.a_im;
            st_re[pb] = bf.b_re;
            st_im[pb] = bf.b_im;
        end
    end

    // Control FSM, buffer updates and registered output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LOAD;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            for (int i = 0; i < 8; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else if (en) begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        mem_re[bitrev3(cnt)] <= in_re;
                        mem_im[bitrev3(cnt)] <= in_im;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) state <= ST1;
                    end
                end
                ST1, ST2: begin
                    for (int i = 0; i < 8; i++) begin
                        mem_re[i] <= st_re[i];
                        mem_im[i] <= st_im[i];
                    end
                    state <= (state == ST1) ? ST2 : ST3;
                end
                ST3: begin
                    for (int i = 0; i < 8; i++) begin
                        mem_re[i] <= st_re[i];
                        mem_im[i] <= st_im[i];
                    end
                    state     <= UNLOAD;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    out_re    <= st_re[0];
                    out_im    <= st_im[0];
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (cnt == 3'd7) begin
                            state     <= LOAD;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_re    <= '0;
                            out_im    <= '0;
                        end else begin
                            cnt      <= cnt + 3'd1;
                            out_re   <= mem_re[cnt + 3'd1];
                            out_im   <= mem_im[cnt + 3'd1];
                            out_last <= (cnt == 3'd6);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_8point_16bit_stream.sv
// Bench for the 8-point streaming IFFT: scoreboard of expected samples,
// filled when a frame is driven and drained against captured outputs.
module tb_ifft_8point_16bit_stream;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic                out_last;

    typedef struct {
        int re;
        int im;
        bit last;
    } samp_t;

    samp_t exp_q[$];
    samp_t obs_q[$];
    int    checks = 0;
    int    errors = 0;

    ifft_8point_16bit_stream #(.W(W), .C45(23170)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int r45(input int d);
        return (d * 23170 + 16384) >>> 15;
    endfunction

    function automatic int w16(input int x);
        shortint s;
        s = shortint'(x);
        return int'(s);
    endfunction

    // Reference IFFT: generic iterative radix-2 DIT with twiddles exp(+j*2*pi*k/8).
    function automatic void model_push(input int xr[8], input int xi[8]);
        int yr[8], yi[8];
        int a, b, half, span, k, tr, ti, ar, ai, rv;
        for (int n = 0; n < 8; n++) begin
            rv = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            yr[rv] = xr[n];
            yi[rv] = xi[n];
        end
        for (int s = 0; s < 3; s++) begin
            half = 1 << s;
            span = half * 2;
            for (int g = 0; g < 8; g += span) begin
                for (int j = 0; j < half; j++) begin
                    a = g + j;
                    b = a + half;
                    k = j * (8 / span);
                    case (k)
                        0: begin tr = yr[b]; ti = yi[b]; end
                        1: begin tr = r45(yr[b] - yi[b]); ti = r45(yr[b] + yi[b]); end
                        2: begin tr = -yi[b]; ti = yr[b]; end
                        default: begin tr = r45(-(yr[b] + yi[b])); ti = r45(yr[b] - yi[b]); end
                    endcase
                    ar = yr[a];
                    ai = yi[a];
                    yr[a] = w16((ar + tr) >>> 1);
                    yi[a] = w16((ai + ti) >>> 1);
                    yr[b] = w16((ar - tr) >>> 1);
                    yi[b] = w16((ai - ti) >>> 1);
                end
            end
        end
        for (int n = 0; n < 8; n++) exp_q.push_back('{yr[n], yi[n], (n == 7)});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int xr[8], input int xi[8], input bit gappy, output bit ok);
        int n;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (gappy && k > 0) begin
                in_valid = 1'b0;
                in_re    = 16'sd1234;
                in_im    = -16'sd77;
                tick();
            end
            in_valid = 1'b1;
            in_re    = 16'(xr[k]);
            in_im    = 16'(xi[k]);
            n = 0;
            while (in_ready !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) ok = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
    endtask

    task automatic capture(input int n_take, input int stall_idx, input int stall_len,
                           output int wait_cycles, output bit stall_ok, output bit idle_after);
        samp_t snap;
        out_ready   = 1'b1;
        stall_ok    = 1'b1;
        wait_cycles = 0;
        while (out_valid !== 1'b1 && wait_cycles < 50) begin
            tick();
            wait_cycles++;
        end
        for (int i = 0; i < n_take; i++) begin
            if (i == stall_idx) begin
                out_ready = 1'b0;
                snap = '{int'(out_re), int'(out_im), out_last};
                repeat (stall_len) begin
                    tick();
                    if (int'(out_re) != snap.re || int'(out_im) != snap.im ||
                        out_last !== snap.last || out_valid !== 1'b1 || in_ready !== 1'b0)
                        stall_ok = 1'b0;
                end
                out_ready = 1'b1;
            end
            obs_q.push_back('{(out_valid === 1'b1) ? int'(out_re) : 99999, int'(out_im), out_last});
            tick();
        end
        idle_after = (out_valid === 1'b0) && (in_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_re = '0; in_im = '0;
        tick();
        tick();
        rst = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (out_re !== 16'sd0 || out_im !== 16'sd0) begin errors++; $display("FAIL reset_out_data got (%0d,%0d) want (0,0)", out_re, out_im); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        en = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_en0 got %b want 0", in_ready); end
        en = 1'b1;
        tick();
    endtask

    task automatic test_impulse();
        int xr[8], xi[8], w; bit ok, st, idle; samp_t e, o;
        for (int i = 0; i < 8; i++) begin xr[i] = 0; xi[i] = 0; end
        xr[0] = 800;
        for (int i = 0; i < 8; i++) exp_q.push_back('{100, 0, (i == 7)});
        load_frame(xr, xi, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL impulse_load got timeout want handshake"); end
        capture(8, -1, 0, w, st, idle);
        checks++; if (w != 3) begin errors++; $display("FAIL impulse_latency got %0d want 3", w); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL impulse_idle_after got %b want 1", idle); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL impulse_missing got none want (%0d,%0d)", e.re, e.im); end
            else begin
                o = obs_q.pop_front();
                if (o.re != e.re || o.im != e.im || o.last != e.last) begin errors++;
                    $display("FAIL impulse_sample got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.re, o.im, o.last, e.re, e.im, e.last); end
            end
        end
    endtask

    task automatic test_constant();
        int xr[8], xi[8], w; bit ok, st, idle; samp_t e, o;
        for (int i = 0; i < 8; i++) begin xr[i] = 8; xi[i] = 0; end
        for (int i = 0; i < 8; i++) exp_q.push_back('{(i == 0) ? 8 : 0, 0, (i == 7)});
        load_frame(xr, xi, 1'b0, ok);
        capture(8, -1, 0, w, st, idle);
        checks++; if (ok !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL const_handshake got ok=%b idle=%b want 1 1", ok, idle); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL const_missing got none want (%0d,%0d)", e.re, e.im); end
            else begin
                o = obs_q.pop_front();
                if (o.re != e.re || o.im != e.im || o.last != e.last) begin errors++;
                    $display("FAIL const_sample got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.re, o.im, o.last, e.re, e.im, e.last); end
            end
        end
    endtask

    task automatic test_bin2();
        int xr[8], xi[8], er[8], ei[8], w; bit ok, st, idle; samp_t e, o;
        er = '{0, -100, 0, 100, 0, -100, 0, 100};
        ei = '{100, 0, -100, 0, 100, 0, -100, 0};
        for (int i = 0; i < 8; i++) begin xr[i] = 0; xi[i] = 0; end
        xi[2] = 800;
        for (int i = 0; i < 8; i++) exp_q.push_back('{er[i], ei[i], (i == 7)});
        load_frame(xr, xi, 1'b0, ok);
        capture(8, -1, 0, w, st, idle);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL bin2_missing got none want (%0d,%0d)", e.re, e.im); end
            else begin
                o = obs_q.pop_front();
                if (o.re != e.re || o.im != e.im || o.last != e.last) begin errors++;
                    $display("FAIL bin2_sample got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.re, o.im, o.last, e.re, e.im, e.last); end
            end
        end
    endtask

    task automatic test_gaps_backpressure();
        int xr[8], xi[8], w; bit ok, st, idle; samp_t e, o;
        for (int i = 0; i < 8; i++) begin
            xr[i] = $urandom_range(4000) - 2000;
            xi[i] = $urandom_range(4000) - 2000;
        end
        model_push(xr, xi);
        load_frame(xr, xi, 1'b1, ok);
        in_valid = 1'b1;
        in_re    = 16'sd555;
        in_im    = -16'sd555;
        capture(8, 3, 3, w, st, idle);
        in_valid = 1'b0;
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stall_stable got %b want 1", st); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL bp_idle_after got %b want 1", idle); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL bp_missing got none want (%0d,%0d)", e.re, e.im); end
            else begin
                o = obs_q.pop_front();
                if (o.re != e.re || o.im != e.im || o.last != e.last) begin errors++;
                    $display("FAIL bp_sample got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.re, o.im, o.last, e.re, e.im, e.last); end
            end
        end
    endtask

    task automatic test_freeze();
        int xr[8], xi[8], w; bit ok, st, idle, frozen_ok; samp_t e, o;
        for (int i = 0; i < 8; i++) begin
            xr[i] = $urandom_range(20000) - 10000;
            xi[i] = $urandom_range(20000) - 10000;
        end
        model_push(xr, xi);
        load_frame(xr, xi, 1'b0, ok);
        tick();
        en = 1'b0;
        frozen_ok = 1'b1;
        repeat (5) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b0) frozen_ok = 1'b0;
        end
        en = 1'b1;
        capture(8, -1, 0, w, st, idle);
        checks++; if (frozen_ok !== 1'b1) begin errors++; $display("FAIL freeze_quiet got %b want 1", frozen_ok); end
        checks++; if (w + 6 != 8) begin errors++; $display("FAIL freeze_latency got %0d want 8", w + 6); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL freeze_missing got none want (%0d,%0d)", e.re, e.im); end
            else begin
                o = obs_q.pop_front();
                if (o.re != e.re || o.im != e.im || o.last != e.last) begin errors++;
                    $display("FAIL freeze_sample got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.re, o.im, o.last, e.re, e.im, e.last); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int xr[8], xi[8], w; bit ok, st, idle; samp_t e, o;
        for (int i = 0; i < 8; i++) begin xr[i] = 100 * (i + 1); xi[i] = -50 * i; end
        model_push(xr, xi);
        load_frame(xr, xi, 1'b0, ok);
        capture(5, -1, 0, w, st, idle);
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.re != e.re || o.im != e.im || o.last != e.last) begin errors++;
                $display("FAIL rstmid_partial got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.re, o.im, o.last, e.re, e.im, e.last); end
        end
        exp_q.delete();
        out_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rstmid_out got valid=%b last=%b want 0 0", out_valid, out_last); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 8; i++) begin xr[i] = -300 + 70 * i; xi[i] = 40 * i; end
        model_push(xr, xi);
        load_frame(xr, xi, 1'b0, ok);
        capture(8, -1, 0, w, st, idle);
        checks++; if (w != 3) begin errors++; $display("FAIL rstmid_latency got %0d want 3", w); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL rstmid_missing got none want (%0d,%0d)", e.re, e.im); end
            else begin
                o = obs_q.pop_front();
                if (o.re != e.re || o.im != e.im || o.last != e.last) begin errors++;
                    $display("FAIL rstmid_sample got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.re, o.im, o.last, e.re, e.im, e.last); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int xr[8], xi[8], w; bit ok, st, idle; samp_t e, o;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                xr[i] = int'($urandom_range(65535)) - 32768;
                xi[i] = int'($urandom_range(65535)) - 32768;
            end
            model_push(xr, xi);
            load_frame(xr, xi, 1'b0, ok);
            capture(8, -1, 0, w, st, idle);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_missing got none want (%0d,%0d)", e.re, e.im); end
            else begin
                o = obs_q.pop_front();
                if (o.re != e.re || o.im != e.im || o.last != e.last) begin errors++;
                    $display("FAIL b2b_sample got (%0d,%0d,%0d) want (%0d,%0d,%0d)", o.re, o.im, o.last, e.re, e.im, e.last); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_constant();
        test_bin2();
        test_gaps_backpressure();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
